// File: rtl/imm_extend_pipe_pkg.sv
// Shared constants for the immediate/data extension pipeline.
package imm_ext_pkg;

    localparam int NB_MODE = 3;
    localparam int NB_BYTE = 8;

    localparam logic [NB_MODE-1:0] MODE_SEXT   = 3'd0;
    localparam logic [NB_MODE-1:0] MODE_ZEXT   = 3'd1;
    localparam logic [NB_MODE-1:0] MODE_UPPER  = 3'd2;
    localparam logic [NB_MODE-1:0] MODE_BRANCH = 3'd3;
    localparam logic [NB_MODE-1:0] MODE_SBYTE  = 3'd4;
    localparam logic [NB_MODE-1:0] MODE_ZBYTE  = 3'd5;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Upstream/downstream handshake bundle of the extension pipeline.
interface imm_extend_pipe_if
    import imm_ext_pkg::*;
#(
    parameter int NB_IN  = 16,
    parameter int NB_OUT = 32,
    parameter int NB_TAG = 5
);
    logic                 i_flush;
    logic                 i_valid;
    logic                 o_ready;
    logic [NB_IN-1:0]     i_data;
    logic [NB_MODE-1:0]   i_mode;
    logic [NB_TAG-1:0]    i_tag;
    logic                 o_valid;
    logic                 i_ready;
    logic [NB_OUT-1:0]    o_data;
    logic [NB_TAG-1:0]    o_tag;
    logic                 o_mode_err;

    modport master (
        output i_flush, i_valid, i_data, i_mode, i_tag, i_ready,
        input  o_ready, o_valid, o_data, o_tag, o_mode_err
    );

    modport slave (
        input  i_flush, i_valid, i_data, i_mode, i_tag, i_ready,
        output o_ready, o_valid, o_data, o_tag, o_mode_err
    );

endinterface

// File: rtl/imm_extend_pipe_core.sv
// Combinational extension of an NB_IN-bit field to NB_OUT bits by mode.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int NB_IN  = 16,
    parameter int NB_OUT = 32
) (
    input  logic [NB_IN-1:0]   i_data,
    input  logic [NB_MODE-1:0] i_mode,
    output logic [NB_OUT-1:0]  o_data,
    output logic               o_err
);

    logic [NB_OUT-1:0] sext;
    logic [NB_OUT-1:0] zext;
    logic [NB_OUT-1:0] upper;
    logic [NB_OUT-1:0] branch;
    logic [NB_OUT-1:0] sbyte;
    logic [NB_OUT-1:0] zbyte;

    assign sext   = {{(NB_OUT-NB_IN){i_data[NB_IN-1]}}, i_data};
    assign zext   = {{(NB_OUT-NB_IN){1'b0}}, i_data};
    assign upper  = {i_data, {(NB_OUT-NB_IN){1'b0}}};
    // Word offset to byte offset: top two bits of the sign extension fall off.
    assign branch = {sext[NB_OUT-3:0], 2'b00};
    assign sbyte  = {{(NB_OUT-NB_BYTE){i_data[NB_BYTE-1]}}, i_data[NB_BYTE-1:0]};
    assign zbyte  = {{(NB_OUT-NB_BYTE){1'b0}}, i_data[NB_BYTE-1:0]};

    always_comb begin
        o_data = '0;
        o_err  = 1'b0;
        case (i_mode)
            MODE_SEXT:   o_data = sext;
            MODE_ZEXT:   o_data = zext;
            MODE_UPPER:  o_data = upper;
            MODE_BRANCH: o_data = branch;
            MODE_SBYTE:  o_data = sbyte;
            MODE_ZBYTE:  o_data = zbyte;
            default:     o_err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Extension unit with a registered output stage and a one-entry skid behind it,
// giving two entries of storage so a stalled downstream never loses data.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int NB_IN  = 16,
    parameter int NB_OUT = 32,
    parameter int NB_TAG = 5
) (
    input  logic         i_clock,
    input  logic         i_reset,
    imm_extend_pipe_if.slave bus
);

    logic [NB_OUT-1:0] ext_data;
    logic              ext_err;

    imm_ext_core #(.NB_IN(NB_IN), .NB_OUT(NB_OUT)) u_core (
        .i_data (bus.i_data),
        .i_mode (bus.i_mode),
        .o_data (ext_data),
        .o_err  (ext_err)
    );

    logic              out_valid_q, out_valid_d;
    logic [NB_OUT-1:0] out_data_q,  out_data_d;
    logic [NB_TAG-1:0] out_tag_q,   out_tag_d;
    logic              out_err_q,   out_err_d;
    logic              skid_valid_q, skid_valid_d;
    logic [NB_OUT-1:0] skid_data_q,  skid_data_d;
    logic [NB_TAG-1:0] skid_tag_q,   skid_tag_d;
    logic              skid_err_q,   skid_err_d;
    logic              ready_q,      ready_d;

    logic accept;
    logic advance;

    assign accept  = bus.i_valid && ready_q && !bus.i_flush;
    assign advance = !out_valid_q || bus.i_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;

        if (bus.i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (advance) begin
            if (skid_valid_q) begin
                // Older skid entry goes out first to keep FIFO order.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_tag_d    = skid_tag_q;
                out_err_d    = skid_err_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = ext_data;
                    skid_tag_d  = bus.i_tag;
                    skid_err_d  = ext_err;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = ext_data;
                    out_tag_d  = bus.i_tag;
                    out_err_d  = ext_err;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_data;
            skid_tag_d   = bus.i_tag;
            skid_err_d   = ext_err;
        end

        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.o_valid    = out_valid_q;
    assign bus.o_data     = out_data_q;
    assign bus.o_tag      = out_tag_q;
    assign bus.o_mode_err = out_err_q;
    assign bus.o_ready    = ready_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: mode vector table, backpressure/flush/reset sequences, random scoreboard run.
module tb_imm_extend_pipe;

    localparam int NB_IN  = 16;
    localparam int NB_OUT = 32;
    localparam int NB_TAG = 5;
    localparam int NV     = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.NB_IN(NB_IN), .NB_OUT(NB_OUT), .NB_TAG(NB_TAG)) bus ();

    imm_extend_pipe #(.NB_IN(NB_IN), .NB_OUT(NB_OUT), .NB_TAG(NB_TAG)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  mode;
        logic [4:0]  tag;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];

    // Independent reference written against the 16->32 case.
    function automatic exp_t ref_ext(input logic [15:0] d, input logic [2:0] m, input logic [4:0] t);
        exp_t e;
        e.tag = t;
        e.err = 1'b0;
        case (m)
            3'd0: e.data = {{16{d[15]}}, d};
            3'd1: e.data = {16'h0000, d};
            3'd2: e.data = {d, 16'h0000};
            3'd3: e.data = {{14{d[15]}}, d, 2'b00};
            3'd4: e.data = {{24{d[7]}}, d[7:0]};
            3'd5: e.data = {24'h000000, d[7:0]};
            default: begin e.data = 32'h0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] m, input logic [4:0] t);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_mode  = m;
        bus.i_tag   = t;
    endtask

    logic  held;
    exp_t  snap;
    exp_t  got;
    exp_t  e;

    initial begin
        vecs[0]  = '{16'h8F80, 3'd0, 5'd3,  32'hFFFF8F80, 1'b0};
        vecs[1]  = '{16'h8F80, 3'd1, 5'd3,  32'h00008F80, 1'b0};
        vecs[2]  = '{16'h8F80, 3'd2, 5'd3,  32'h8F800000, 1'b0};
        vecs[3]  = '{16'h8F80, 3'd3, 5'd3,  32'hFFFE3E00, 1'b0};
        vecs[4]  = '{16'h8F80, 3'd4, 5'd3,  32'hFFFFFF80, 1'b0};
        vecs[5]  = '{16'h8F80, 3'd5, 5'd3,  32'h00000080, 1'b0};
        vecs[6]  = '{16'h1234, 3'd6, 5'd7,  32'h00000000, 1'b1};
        vecs[7]  = '{16'hFFFF, 3'd7, 5'd8,  32'h00000000, 1'b1};
        vecs[8]  = '{16'h7FFF, 3'd0, 5'd9,  32'h00007FFF, 1'b0};
        vecs[9]  = '{16'h0001, 3'd3, 5'd10, 32'h00000004, 1'b0};
        vecs[10] = '{16'h127F, 3'd4, 5'd11, 32'h0000007F, 1'b0};
        vecs[11] = '{16'hFFFF, 3'd2, 5'd31, 32'hFFFF0000, 1'b0};

        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        drive(1'b0, 16'h0, 3'd0, 5'd0);

        // Reset state
        #12;
        check("rst_ready",  bus.o_ready, 0);
        check("rst_valid",  bus.o_valid, 0);
        check("rst_data",   bus.o_data, 0);
        check("rst_tag",    bus.o_tag, 0);
        check("rst_err",    bus.o_mode_err, 0);
        #5 rst_n = 1'b1;
        #5;
        check("rel_ready_before_edge", bus.o_ready, 0);
        @(negedge clk);
        check("rel_ready_after_edge", bus.o_ready, 1);

        // Mode vector table
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].data, vecs[i].mode, vecs[i].tag);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), bus.o_valid, 1);
            check($sformatf("vec%0d_data", i),  bus.o_data, vecs[i].exp_data);
            check($sformatf("vec%0d_tag", i),   bus.o_tag, vecs[i].tag);
            check($sformatf("vec%0d_err", i),   bus.o_mode_err, vecs[i].exp_err);
            drive(1'b0, 16'h0, 3'd0, 5'd0);
            @(negedge clk);
        end
        check("idle_valid", bus.o_valid, 0);

        // Backpressure: output + skid fill, third entry held upstream
        bus.i_ready = 1'b0;
        drive(1'b1, 16'h0011, 3'd1, 5'd1);
        @(negedge clk);
        check("bp_first_ready", bus.o_ready, 1);
        drive(1'b1, 16'h0022, 3'd1, 5'd2);
        @(negedge clk);
        check("bp_skid_ready", bus.o_ready, 0);
        check("bp_hold_tag",   bus.o_tag, 1);
        drive(1'b1, 16'h0033, 3'd1, 5'd3);
        @(negedge clk);
        check("bp_full_ready", bus.o_ready, 0);
        check("bp_full_tag",   bus.o_tag, 1);
        check("bp_full_data",  bus.o_data, 32'h00000011);
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("bp_out2_tag",   bus.o_tag, 2);
        check("bp_out2_data",  bus.o_data, 32'h00000022);
        check("bp_out2_ready", bus.o_ready, 1);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 5'd0);
        check("bp_out3_tag",   bus.o_tag, 3);
        check("bp_out3_data",  bus.o_data, 32'h00000033);
        check("bp_out3_valid", bus.o_valid, 1);
        @(negedge clk);
        check("bp_drain_valid", bus.o_valid, 0);

        // Flush with output and skid both full
        bus.i_ready = 1'b0;
        drive(1'b1, 16'h0044, 3'd1, 5'd4);
        @(negedge clk);
        drive(1'b1, 16'h0055, 3'd1, 5'd5);
        @(negedge clk);
        check("fl_pre_ready", bus.o_ready, 0);
        bus.i_flush = 1'b1;
        drive(1'b1, 16'h0099, 3'd1, 5'd9);
        @(negedge clk);
        bus.i_flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 5'd0);
        check("fl_valid", bus.o_valid, 0);
        check("fl_ready", bus.o_ready, 1);
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("fl_after1_valid", bus.o_valid, 0);
        @(negedge clk);
        check("fl_after2_valid", bus.o_valid, 0);

        // Asynchronous reset while an entry is held
        bus.i_ready = 1'b0;
        drive(1'b1, 16'h0066, 3'd1, 5'd6);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 5'd0);
        check("ar_pre_valid", bus.o_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", bus.o_valid, 0);
        check("ar_ready", bus.o_ready, 0);
        check("ar_data",  bus.o_data, 0);
        check("ar_tag",   bus.o_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("ar_rel_ready", bus.o_ready, 1);
        drive(1'b1, 16'h0001, 3'd0, 5'd12);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 5'd0);
        check("ar_sext_valid", bus.o_valid, 1);
        check("ar_sext_data",  bus.o_data, 32'h00000001);
        check("ar_sext_tag",   bus.o_tag, 12);
        @(negedge clk);

        // Random stress against a scoreboard
        held = 1'b0;
        snap = '0;
        sb.delete();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (held) begin
                check("st_stable_data", bus.o_data, snap.data);
                check("st_stable_tag",  bus.o_tag, snap.tag);
                check("st_stable_err",  bus.o_mode_err, snap.err);
            end
            check("st_valid", bus.o_valid, (sb.size() > 0));
            check("st_ready", bus.o_ready, (sb.size() < 2));

            bus.i_flush = ($urandom_range(0, 99) < 2);
            bus.i_ready = ($urandom_range(0, 99) < 60);
            drive(($urandom_range(0, 99) < 70), 16'($urandom), 3'($urandom_range(0, 7)), 5'($urandom));
            #1;
            held = bus.o_valid && !bus.i_ready && !bus.i_flush;
            snap = '{bus.o_data, bus.o_tag, bus.o_mode_err};
            if (bus.i_flush) begin
                sb.delete();
            end else begin
                if (bus.o_valid && bus.i_ready) begin
                    got = '{bus.o_data, bus.o_tag, bus.o_mode_err};
                    if (sb.size() == 0) begin
                        check("st_pop_nonempty", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        check("st_data", got.data, e.data);
                        check("st_tag",  got.tag, e.tag);
                        check("st_err",  got.err, e.err);
                    end
                end
                if (bus.i_valid && bus.o_ready)
                    sb.push_back(ref_ext(bus.i_data, bus.i_mode, bus.i_tag));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
